sum_sequencer: RTL

- Sequences one reduction pass over a word-addressed memory, and is the controller behind the top-level done/sum/cycle indications.
- On start, it issues DEPTH pipelined read requests at addresses 0..DEPTH-1 over a grant/valid handshake.
- It accumulates the returned words into a wrapping sum, counts the cycles spent in the pass, and asserts a level done.
- It sits between ChipInterface control (KEY/SW) and the data memory.

---
 rtl/sum_sequencer_if.sv | 28 ++
 rtl/sum_sequencer.sv | 115 +++++++++++
 2 files changed

// File: rtl/sum_sequencer_if.sv
// Memory read channel between the sum sequencer (master) and a word memory (slave).
// Requests use a grant handshake; returns come back in issue order on mem_rvalid.
interface sum_sequencer_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) ();
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rvalid;

    modport master (
        output mem_rd,
        output mem_addr,
        input  mem_gnt,
        input  mem_rdata,
        input  mem_rvalid
    );

    modport slave (
        input  mem_rd,
        input  mem_addr,
        output mem_gnt,
        output mem_rdata,
        output mem_rvalid
    );
endinterface

// File: rtl/sum_sequencer.sv
// Reads DEPTH words with up to MAX_OUT reads in flight, sums the returns and
// reports the pass length; unsolicited returns raise a sticky error.
module sum_sequencer #(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 16,
    parameter int SUM_W   = 32,
    parameter int CYC_W   = 32,
    parameter int MAX_OUT = 4
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             start,
    sum_sequencer_if.master  mem,
    output logic [SUM_W-1:0] sum,
    output logic [CYC_W-1:0] cycle,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int OUT_W = $clog2(MAX_OUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [OUT_W-1:0]  MAX_OUT_V = OUT_W'(MAX_OUT);

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [ADDR_W-1:0] r_addr;
    logic [OUT_W-1:0]  r_out;
    logic [OUT_W-1:0]  w_out_next;
    logic [SUM_W-1:0]  r_sum;
    logic [CYC_W-1:0]  r_cycle;
    logic              r_err;
    logic              w_busy;
    logic              w_start;
    logic              w_rd;
    logic              w_xfer;
    logic              w_ret;
    logic              w_spur;

    assign w_busy  = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    assign w_start = start && !w_busy;
    // Request depends on registered credit only, so a credit freed this cycle waits one cycle.
    assign w_rd    = (r_state == S_ISSUE) && (r_out < MAX_OUT_V);
    assign w_xfer  = w_rd && mem.mem_gnt;
    assign w_ret   = mem.mem_rvalid && (r_out != '0);
    assign w_spur  = mem.mem_rvalid && (r_out == '0);

    always_comb begin
        w_out_next = r_out;
        if (w_xfer && !w_ret) begin
            w_out_next = r_out + OUT_W'(1);
        end else if (!w_xfer && w_ret) begin
            w_out_next = r_out - OUT_W'(1);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start)                           w_state_next = S_ISSUE;
            S_ISSUE:        if (w_xfer && r_addr == LAST_ADDR)   w_state_next = S_DRAIN;
            S_DRAIN:        if (w_out_next == '0)                w_state_next = S_DONE;
            default:                                             w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_out   <= '0;
            r_sum   <= '0;
            r_cycle <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_start) begin
                r_addr  <= '0;
                r_out   <= '0;
                r_sum   <= '0;
                r_cycle <= '0;
                r_err   <= 1'b0;
            end else begin
                r_out <= w_out_next;
                if (w_ret) begin
                    r_sum <= r_sum + SUM_W'(mem.mem_rdata);
                end
                if (w_spur) begin
                    r_err <= 1'b1;
                end
                if (w_busy && (r_cycle != '1)) begin
                    r_cycle <= r_cycle + CYC_W'(1);
                end
                // The address parks on the last word rather than wrapping.
                if (w_xfer && (r_addr != LAST_ADDR)) begin
                    r_addr <= r_addr + ADDR_W'(1);
                end
            end
        end
    end

    assign mem.mem_rd   = w_rd;
    assign mem.mem_addr = r_addr;
    assign sum          = r_sum;
    assign cycle        = r_cycle;
    assign busy         = w_busy;
    assign done         = (r_state == S_DONE);
    assign err          = r_err;
endmodule
